// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the serial CRC-4 frame scheduler:
//   MSG_W_DEFAULT  default message width (bits per frame, shifted MSB first)
//   CRC_W          CRC width
//   POLY           generator low bits (x^4 + x + 1, x^CRC_W term implicit)
//   state_t        scheduler FSM states
//   crc_step()     one bit of register long-division; used by the engine and
//                  by any reference model so both share a single definition
// -----------------------------------------------------------------------------
package crc_pkg;

    localparam int               MSG_W_DEFAULT = 7;
    localparam int               CRC_W         = 4;
    localparam logic [CRC_W-1:0] POLY          = 4'b0011;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Shift one bit in; when the bit falling out of the top is set, the
    // generator is subtracted (XOR) from what remains.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                  input logic             din);
        return {crc[CRC_W-2:0], din} ^ (crc[CRC_W-1] ? POLY : '0);
    endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// -----------------------------------------------------------------------------
// crc_serial_lfsr
// The serial CRC engine register. One bit of long-division per enabled cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (clears the register)
//   clr    synchronous clear at the start of a frame (wins over en)
//   en     advance the engine by one bit
//   din    serial input bit
//   crc    current remainder
// -----------------------------------------------------------------------------
module crc_serial_lfsr
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [CRC_W-1:0] crc
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc_step(crc, din);
        end
    end

endmodule

// File: rtl/crc_frame_sched.sv
// -----------------------------------------------------------------------------
// crc_frame_sched
// Shares one serial CRC-4 engine between two requesters. A granted frame is
// latched together with the CRC_W trailing bits (zeros in generate mode, the
// received CRC in check mode) into one shift register that feeds the engine
// MSB first, MSG_W+CRC_W bits in total. The remainder is reported with a
// one-cycle done pulse. Simultaneous requests are served round-robin.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   req      per-requester level request, held until ack
//   req_chk  per-requester mode: 0 = generate, 1 = check
//   req_msg  frames, requester i at [i*MSG_W +: MSG_W]
//   req_exp  received CRCs, requester i at [i*CRC_W +: CRC_W]
//   ack      one-cycle grant pulse (frame latched on the edge that raises it)
//   busy     high while a frame is shifting
//   done     one-cycle result pulse
//   done_id  requester index of the finished frame
//   crc_out  remainder, held until the next done
//   crc_ok   check mode and remainder zero
// Timing: the ack cycle is followed by MSG_W+CRC_W shift edges; done is high
// in the cycle after the last one, i.e. the 12th cycle counting the ack cycle
// as the first. The edge ending the done cycle can already grant a new frame.
// -----------------------------------------------------------------------------
module crc_frame_sched
    import crc_pkg::*;
#(
    parameter int MSG_W = MSG_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [1:0]         req_chk,
    input  logic [2*MSG_W-1:0] req_msg,
    input  logic [2*CRC_W-1:0] req_exp,
    output logic [1:0]         ack,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [CRC_W-1:0]   crc_out,
    output logic               crc_ok
);

    localparam int               TOT_W    = MSG_W + CRC_W;
    localparam int               CNT_W    = $clog2(TOT_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOT_W - 1);

    state_t             state_q;
    state_t             state_d;
    logic               last_q;
    logic [TOT_W-1:0]   sr_q;
    logic               chk_q;
    logic               id_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               grant;
    logic               win;
    logic               lfsr_clr;
    logic               lfsr_en;
    logic               last_edge;
    logic               din;
    logic [CRC_W-1:0]   crc_q;
    logic [CRC_W-1:0]   crc_next;
    logic [MSG_W-1:0]   msg_sel;
    logic [CRC_W-1:0]   exp_sel;
    logic               chk_sel;

    assign din      = sr_q[TOT_W-1];
    assign crc_next = crc_step(crc_q, din);
    assign msg_sel  = win ? req_msg[2*MSG_W-1:MSG_W] : req_msg[MSG_W-1:0];
    assign exp_sel  = win ? req_exp[2*CRC_W-1:CRC_W] : req_exp[CRC_W-1:0];
    assign chk_sel  = win ? req_chk[1] : req_chk[0];

    crc_serial_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .clr   (lfsr_clr),
        .en    (lfsr_en),
        .din   (din),
        .crc   (crc_q)
    );

    // Next-state logic and arbitration. On a tie the requester that was not
    // granted last wins; last_q resets to 1 so requester 0 wins the first tie.
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        win       = 1'b0;
        lfsr_clr  = 1'b0;
        lfsr_en   = 1'b0;
        last_edge = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant    = 1'b1;
                    win      = (req == 2'b11) ? ~last_q : req[1];
                    lfsr_clr = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_en = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last_edge = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, frame and result registers. In generate mode the trailing
    // CRC_W bits of the shift register are loaded with zeros (augmentation),
    // so the same shift path serves both modes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            sr_q    <= '0;
            chk_q   <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            ack     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            crc_out <= '0;
            crc_ok  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack     <= 2'b00;
            done    <= 1'b0;
            if (grant) begin
                ack    <= win ? 2'b10 : 2'b01;
                last_q <= win;
                id_q   <= win;
                chk_q  <= chk_sel;
                sr_q   <= {msg_sel, (chk_sel ? exp_sel : {CRC_W{1'b0}})};
                cnt_q  <= '0;
                busy   <= 1'b1;
            end
            if (lfsr_en) begin
                sr_q  <= {sr_q[TOT_W-2:0], 1'b0};
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_edge) begin
                crc_out <= crc_next;
                crc_ok  <= chk_q && (crc_next == '0);
                done    <= 1'b1;
                done_id <= id_q;
                busy    <= 1'b0;
            end
        end
    end

endmodule
